// File: rtl/alu_integer_seq.sv
// Sequential signed saturating integer ALU: add/sub in one cycle, mul/mac through
// an iterative shift-add datapath, with valid/ready handshakes on both sides.
module alu_integer_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            opcode,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  clear_acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  N,
    output logic                  V,
    output logic                  Z,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int XW = 2 * W + 1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic signed [XW-1:0] SAT_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [2*W-1:0]  mcand_reg, mcand_next;
    logic [2*W-1:0]  prod_reg, prod_next;
    logic [W-1:0]    mplier_reg, mplier_next;
    logic            sign_reg, sign_next;
    logic            is_mac_reg, is_mac_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [W-1:0]    acc_reg, acc_next;
    logic [W-1:0]    out_reg, out_next;
    logic            n_reg, n_next;
    logic            v_reg, v_next;
    logic            z_reg, z_next;

    // Returns {clamped, value} for a wide signed intermediate result.
    function automatic logic [W:0] saturate(input logic signed [XW-1:0] x);
        logic [W:0] r;
        if (x > SAT_MAX) begin
            r = {1'b1, 1'b0, {(W - 1){1'b1}}};
        end else if (x < SAT_MIN) begin
            r = {1'b1, 1'b1, {(W - 1){1'b0}}};
        end else begin
            r = {1'b0, x[W-1:0]};
        end
        return r;
    endfunction

    logic [W-1:0]        abs_a, abs_b;
    logic signed [W:0]   a_w, b_w, addsub_w;
    logic [XW-1:0]       addsub_x;
    logic [2*W-1:0]      step_addend, step_sum;
    logic [XW-1:0]       mag_x, prod_x, acc_x, final_x, sat_in;
    logic [W-1:0]        acc_eff;
    logic [W:0]          sat_res;

    // Negating the most negative value yields 2^(W-1), which is correct as unsigned.
    assign abs_a = A[W-1] ? -A : A;
    assign abs_b = B[W-1] ? -B : B;

    assign a_w      = {A[W-1], A};
    assign b_w      = {B[W-1], B};
    assign addsub_w = opcode[0] ? (a_w - b_w) : (a_w + b_w);
    assign addsub_x = {{W{addsub_w[W]}}, addsub_w};

    assign step_addend = mplier_reg[0] ? mcand_reg : '0;
    assign step_sum    = prod_reg + step_addend;

    // A clear on the finalizing edge takes precedence over the old accumulator.
    assign acc_eff = clear_acc ? '0 : acc_reg;
    assign mag_x   = {1'b0, step_sum};
    assign prod_x  = sign_reg ? -mag_x : mag_x;
    assign acc_x   = {{(W + 1){acc_eff[W-1]}}, acc_eff};
    assign final_x = is_mac_reg ? (acc_x + prod_x) : prod_x;

    assign sat_in  = (state_reg == MUL) ? final_x : addsub_x;
    assign sat_res = saturate(sat_in);

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        prod_next   = prod_reg;
        mplier_next = mplier_reg;
        sign_next   = sign_reg;
        is_mac_next = is_mac_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_eff;
        out_next    = out_reg;
        n_next      = n_reg;
        v_next      = v_reg;
        z_next      = z_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (!opcode[1]) begin
                        out_next   = sat_res[W-1:0];
                        v_next     = sat_res[W];
                        n_next     = sat_res[W-1];
                        z_next     = (sat_res[W-1:0] == '0);
                        state_next = DONE;
                    end else begin
                        mcand_next  = {{W{1'b0}}, abs_a};
                        mplier_next = abs_b;
                        prod_next   = '0;
                        sign_next   = A[W-1] ^ B[W-1];
                        is_mac_next = opcode[0];
                        cnt_next    = '0;
                        state_next  = MUL;
                    end
                end
            end
            MUL: begin
                prod_next   = step_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_STEP) begin
                    out_next   = sat_res[W-1:0];
                    v_next     = sat_res[W];
                    n_next     = sat_res[W-1];
                    z_next     = (sat_res[W-1:0] == '0);
                    cnt_next   = '0;
                    state_next = DONE;
                    if (is_mac_reg) begin
                        acc_next = sat_res[W-1:0];
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            mplier_reg <= '0;
            sign_reg   <= 1'b0;
            is_mac_reg <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            out_reg    <= '0;
            n_reg      <= 1'b0;
            v_reg      <= 1'b0;
            z_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            prod_reg   <= prod_next;
            mplier_reg <= mplier_next;
            sign_reg   <= sign_next;
            is_mac_reg <= is_mac_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            out_reg    <= out_next;
            n_reg      <= n_next;
            v_reg      <= v_next;
            z_reg      <= z_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == MUL);
    assign Out       = out_reg;
    assign N         = n_reg;
    assign V         = v_reg;
    assign Z         = z_reg;

endmodule

// File: tb/tb_alu_integer_seq.sv
// Randomized and directed bench for alu_integer_seq against an integer-arithmetic model.
module tb_alu_integer_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    opcode = 2'd0;
    logic [DW-1:0] A = '0;
    logic [DW-1:0] B = '0;
    logic          clear_acc = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] Out;
    logic          N, V, Z, busy;

    int n_checks = 0;
    int n_errors = 0;
    int acc_m = 0;

    alu_integer_seq #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .A(A), .B(B), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
        .N(N), .V(V), .Z(Z), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer result, then clamp to the signed 8-bit range.
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input bit clr, output logic [7:0] r, output bit n,
                                  output bit v, output bit z);
        int sa, sb, x;
        sa = {{24{a[7]}}, a};
        sb = {{24{b[7]}}, b};
        if (clr) acc_m = 0;
        case (op)
            2'd0:    x = sa + sb;
            2'd1:    x = sa - sb;
            2'd2:    x = sa * sb;
            default: x = acc_m + sa * sb;
        endcase
        v = 1'b0;
        if (x > 127) begin
            x = 127;
            v = 1'b1;
        end else if (x < -128) begin
            x = -128;
            v = 1'b1;
        end
        if (op == 2'd3) acc_m = x;
        r = x[7:0];
        n = r[7];
        z = (r == 8'h00);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit clr);
        logic [7:0] e_out;
        bit e_n, e_v, e_z;
        int lat, busy_cnt, wait_cnt, e_lat;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        opcode    = op;
        A         = a;
        B         = b;
        clear_acc = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_acc = 1'b0;
        opcode    = 2'($urandom);
        A         = 8'($urandom);
        B         = 8'($urandom);
        model(op, a, b, clr, e_out, e_n, e_v, e_z);
        e_lat = op[1] ? DW + 1 : 1;
        lat = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("busy_cycles", 32'(busy_cnt), op[1] ? 32'(DW) : 32'd0);
        check("out", 32'(Out), 32'(e_out));
        check("flag_n", 32'(N), 32'(e_n));
        check("flag_v", 32'(V), 32'(e_v));
        check("flag_z", 32'(Z), 32'(e_z));
        $display("op=%0d A=%02h B=%02h clr=%0d -> Out=%02h N=%0b V=%0b Z=%0b lat=%0d (exp %02h)",
                 op, a, b, clr, Out, N, V, Z, lat, e_out);
    endtask

    initial begin
        int ov_cnt;
        logic [7:0] e_out;
        bit e_n, e_v, e_z;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out", 32'(Out), 32'd0);
        check("rst_flags", 32'({N, V, Z}), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset released: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // Add/sub saturation
        do_op(2'd0, 8'h7F, 8'h01, 1'b0);
        do_op(2'd1, 8'h80, 8'h0A, 1'b0);
        do_op(2'd1, 8'hFF, 8'hFF, 1'b0);

        // Multiply
        do_op(2'd2, 8'hFB, 8'h02, 1'b0);
        do_op(2'd2, 8'hFB, 8'hFE, 1'b0);
        do_op(2'd2, 8'hC0, 8'h0A, 1'b0);
        do_op(2'd2, 8'h80, 8'hFF, 1'b0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 2'd2;
        A        = 8'h05;
        B        = 8'h02;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mul_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(Out), 32'd0);
        check("async_rst_flags", 32'({N, V, Z}), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        acc_m = 0;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        ov_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("discarded_op_no_valid", 32'(ov_cnt), 32'd0);
        $display("mid-mul reset: out_valid cycles after release=%0d", ov_cnt);

        // MAC sequence
        @(negedge clk);
        clear_acc = 1'b1;
        @(posedge clk);
        #1;
        clear_acc = 1'b0;
        acc_m = 0;
        do_op(2'd3, 8'h05, 8'h04, 1'b0);
        do_op(2'd3, 8'h05, 8'h04, 1'b0);
        do_op(2'd3, 8'h7F, 8'h7F, 1'b0);
        do_op(2'd3, 8'h80, 8'h01, 1'b0);
        do_op(2'd3, 8'h02, 8'h03, 1'b1);

        // Backpressure
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        opcode    = 2'd0;
        A         = 8'h04;
        B         = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(2'd0, 8'h04, 8'hFF, 1'b0, e_out, e_n, e_v, e_z);
        ov_cnt = 0;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(negedge clk);
            ov_cnt++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_stable", 32'(Out), 32'(e_out));
            check("bp_flags_stable", 32'({N, V, Z}), 32'({e_n, e_v, e_z}));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            in_valid = 1'b1;
            opcode   = 2'd0;
            A        = 8'h01;
            B        = 8'h01;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        check("bp_out_valid_drop", 32'(out_valid), 32'd0);
        $display("backpressure: Out=%02h held, released in_ready=%0b", Out, in_ready);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
